// File: rtl/bus_cycle_router_if.sv
// CPU-side bus bundle for bus_cycle_router: 68030 strobes, window programming
// and the generated select/termination lines.
interface bus_cycle_router_if #(
    parameter int NWIN = 4,
    parameter int WS_W = 4
);
    logic                   AS30;
    logic                   RW30;
    logic [2:0]             FC;
    logic [31:0]            A;
    logic [NWIN*16-1:0]     WIN_MATCH;
    logic [NWIN*16-1:0]     WIN_MASK;
    logic [NWIN*2-1:0]      WIN_MODE;
    logic [NWIN*WS_W-1:0]   WIN_WS;
    logic [NWIN-1:0]        WIN_SIZE;
    logic [NWIN-1:0]        WIN_RDY;
    logic [1:0]             HOST_DSACK;
    logic [NWIN-1:0]        SEL;
    logic [1:0]             DSACK;
    logic                   PUNT;
    logic                   SPEED;
    logic                   BERR;
    logic                   BUSY;

    modport master (
        output AS30, RW30, FC, A, WIN_MATCH, WIN_MASK, WIN_MODE, WIN_WS,
               WIN_SIZE, WIN_RDY, HOST_DSACK,
        input  SEL, DSACK, PUNT, SPEED, BERR, BUSY
    );

    modport slave (
        input  AS30, RW30, FC, A, WIN_MATCH, WIN_MASK, WIN_MODE, WIN_WS,
               WIN_SIZE, WIN_RDY, HOST_DSACK,
        output SEL, DSACK, PUNT, SPEED, BERR, BUSY
    );
endinterface

// File: rtl/bus_cycle_router.sv
// Routes each 68030 bus cycle to one of NWIN programmable windows or punts it
// to the host bus; generates selects, DSACK sizing, punt/speed and BERR timeout.
module bus_cycle_router #(
    parameter int NWIN    = 4,
    parameter int WS_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             CLKCPU,
    input  logic             RESET,
    bus_cycle_router_if.slave bus
);
    localparam int IW = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] TO_PREV = 8'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_WAIT, S_ACK, S_PUNT, S_BERR, S_TERM
    } state_t;

    state_t            state_q, state_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        mode_q, mode_d;
    logic              size_q, size_d;
    logic              armed_q;
    logic [NWIN-1:0]   sel_q, sel_d;
    logic [1:0]        dsack_q, dsack_d;
    logic              punt_q, punt_d;
    logic              speed_q, speed_d;
    logic              berr_q, berr_d;

    logic              hit;
    logic [IW-1:0]     hit_idx;
    logic [1:0]        hit_mode;
    logic [WS_W-1:0]   hit_ws;
    logic              hit_size;
    logic              hit_rdy;
    logic [NWIN-1:0]   hit_sel;
    logic              unused_ok;

    assign unused_ok = &{1'b0, bus.RW30, bus.A[15:0]};

    // Priority decode: the first enabled window whose masked compare hits wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_mode = 2'b00;
        hit_ws   = '0;
        hit_size = 1'b0;
        hit_rdy  = 1'b0;
        hit_sel  = '0;
        for (int unsigned i = 0; i < NWIN; i++) begin
            if (!hit && bus.WIN_MODE[2*i +: 2] != 2'b00 &&
                ((bus.A[31:16] ^ bus.WIN_MATCH[16*i +: 16]) & bus.WIN_MASK[16*i +: 16]) == 16'h0000) begin
                hit        = 1'b1;
                hit_idx    = IW'(i);
                hit_mode   = bus.WIN_MODE[2*i +: 2];
                hit_ws     = bus.WIN_WS[WS_W*i +: WS_W];
                hit_size   = bus.WIN_SIZE[i];
                hit_rdy    = bus.WIN_RDY[i];
                hit_sel[i] = 1'b1;
            end
        end
        if (bus.FC == 3'b111) hit = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        size_d  = size_q;
        sel_d   = sel_q;
        dsack_d = dsack_q;
        punt_d  = punt_q;
        speed_d = speed_q;
        berr_d  = berr_q;
        case (state_q)
            S_IDLE: if (!bus.AS30 && armed_q) state_d = S_DECODE;
            S_DECODE: begin
                if (bus.AS30) begin
                    state_d = S_TERM;
                end else if (hit && hit_mode != 2'b10) begin
                    idx_d  = hit_idx;
                    mode_d = hit_mode;
                    size_d = hit_size;
                    cnt_d  = hit_ws;
                    tcnt_d = '0;
                    sel_d  = hit_sel;
                    // Zero wait states terminate straight from decode.
                    if (hit_ws == '0 && (hit_mode == 2'b01 || hit_rdy)) begin
                        state_d = S_ACK;
                        dsack_d = hit_size ? 2'b00 : 2'b10;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_PUNT;
                    tcnt_d  = '0;
                    punt_d  = 1'b0;
                    speed_d = 1'b1;
                    dsack_d = bus.HOST_DSACK;
                end
            end
            S_WAIT: begin
                if (bus.AS30) begin
                    state_d = S_TERM;
                end else begin
                    cnt_d = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
                    // Count of 1 here means the wait expires on this edge.
                    if ((cnt_q == '0 || cnt_q == WS_W'(1)) && (mode_q == 2'b01 || bus.WIN_RDY[idx_q])) begin
                        state_d = S_ACK;
                        dsack_d = size_q ? 2'b00 : 2'b10;
                    end else if (tcnt_q >= TO_PREV) begin
                        state_d = S_BERR;
                        tcnt_d  = TO_LAST;
                        berr_d  = 1'b0;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            S_ACK:  if (bus.AS30) state_d = S_TERM;
            S_BERR: if (bus.AS30) state_d = S_TERM;
            S_PUNT: begin
                if (bus.AS30) state_d = S_TERM;
                else          dsack_d = bus.HOST_DSACK;
            end
            S_TERM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_TERM || state_d == S_IDLE) begin
            sel_d   = '0;
            dsack_d = 2'b11;
            punt_d  = 1'b1;
            speed_d = 1'b0;
            berr_d  = 1'b1;
        end
    end

    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            mode_q  <= 2'b00;
            size_q  <= 1'b0;
            armed_q <= bus.AS30;
            sel_q   <= '0;
            dsack_q <= 2'b11;
            punt_q  <= 1'b1;
            speed_q <= 1'b0;
            berr_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            size_q  <= size_d;
            if (bus.AS30) armed_q <= 1'b1;
            sel_q   <= sel_d;
            dsack_q <= dsack_d;
            punt_q  <= punt_d;
            speed_q <= speed_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.SEL   = sel_q;
    assign bus.DSACK = dsack_q;
    assign bus.PUNT  = punt_q;
    assign bus.SPEED = speed_q;
    assign bus.BERR  = berr_q;
    assign bus.BUSY  = (state_q != S_IDLE);
endmodule

// File: tb/tb_bus_cycle_router.sv
// Scoreboard bench for bus_cycle_router: per-edge expected outputs are queued
// with each bus cycle and compared one edge at a time.
module tb_bus_cycle_router;
    typedef struct packed {
        logic [3:0] sel;
        logic [1:0] dsack;
        logic       punt;
        logic       speed;
        logic       berr;
        logic       busy;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    bus_cycle_router_if #(.NWIN(4), .WS_W(4)) bus ();

    bus_cycle_router #(.NWIN(4), .WS_W(4), .TIMEOUT(8)) dut (
        .CLKCPU (clk),
        .RESET  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t o(input logic [3:0] s, input logic [1:0] d,
                               input logic p, input logic sp, input logic b, input logic bz);
        return '{sel: s, dsack: d, punt: p, speed: sp, berr: b, busy: bz};
    endfunction

    function automatic obs_t observe();
        return '{sel: bus.SEL, dsack: bus.DSACK, punt: bus.PUNT,
                 speed: bus.SPEED, berr: bus.BERR, busy: bus.BUSY};
    endfunction

    localparam obs_t IDL = '{sel: 4'b0000, dsack: 2'b11, punt: 1'b1, speed: 1'b0, berr: 1'b1, busy: 1'b0};
    localparam obs_t BSY = '{sel: 4'b0000, dsack: 2'b11, punt: 1'b1, speed: 1'b0, berr: 1'b1, busy: 1'b1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input obs_t v, input int n);
        repeat (n) exp_q.push_back(v);
    endtask

    task automatic clear_windows();
        bus.WIN_MATCH = '0;
        bus.WIN_MASK  = '0;
        bus.WIN_MODE  = '0;
        bus.WIN_WS    = '0;
        bus.WIN_SIZE  = '0;
        bus.WIN_RDY   = '0;
    endtask

    task automatic set_win(input int i, input logic [15:0] m, input logic [15:0] k,
                           input logic [1:0] md, input logic [3:0] ws, input logic sz);
        bus.WIN_MATCH[16*i +: 16] = m;
        bus.WIN_MASK[16*i +: 16]  = k;
        bus.WIN_MODE[2*i +: 2]    = md;
        bus.WIN_WS[4*i +: 4]      = ws;
        bus.WIN_SIZE[i]           = sz;
    endtask

    task automatic start_cycle(input logic [31:0] addr, input logic [2:0] fc);
        bus.A    = addr;
        bus.FC   = fc;
        bus.RW30 = 1'b1;
        bus.AS30 = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        push(IDL, 3);
        for (int k = 1; k <= 3; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 2) rst = 1'b0;
        end
    endtask

    task automatic test_wait_states();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b01, 4'd3, 1'b0);
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b11, 1, 0, 1, 1), 3);
        push(o(4'b0001, 2'b10, 1, 0, 1, 1), 2);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL wait_states edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 6) bus.AS30 = 1'b1;
        end
    endtask

    task automatic test_priority();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b00, 4'd0, 1'b1);
        set_win(1, 16'h00DA, 16'hFFFF, 2'b01, 4'd0, 1'b1);
        set_win(2, 16'h00DA, 16'hFFFF, 2'b01, 4'd0, 1'b1);
        set_win(3, 16'h0000, 16'h0000, 2'b01, 4'd5, 1'b0);
        start_cycle(32'h00DA_1234, 3'b101);
        push(BSY, 1);
        push(o(4'b0010, 2'b00, 1, 0, 1, 1), 2);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL priority edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 3) bus.AS30 = 1'b1;
        end
    endtask

    task automatic test_ext_ready();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b11, 4'd1, 1'b1);
        bus.WIN_RDY = 4'b0001;
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b11, 1, 0, 1, 1), 1);
        push(o(4'b0001, 2'b00, 1, 0, 1, 1), 1);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL ext_ready edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 3) bus.AS30 = 1'b1;
        end
        bus.WIN_RDY = '0;
    endtask

    task automatic test_timeout();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b11, 4'd1, 1'b1);
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b11, 1, 0, 1, 1), 7);
        push(o(4'b0001, 2'b11, 1, 0, 0, 1), 2);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 10) bus.AS30 = 1'b1;
        end
    endtask

    task automatic test_punt();
        obs_t got, exp;
        for (int c = 0; c < 2; c++) begin
            clear_windows();
            bus.HOST_DSACK = 2'b11;
            if (c == 0) begin
                set_win(0, 16'h00DA, 16'hFFFF, 2'b01, 4'd3, 1'b0);
                start_cycle(32'h00BF_E001, 3'b101);
            end else begin
                // Would hit window 0 with zero wait states if not CPU space.
                set_win(0, 16'h000F, 16'hFFFF, 2'b01, 4'd0, 1'b1);
                start_cycle(32'h000F_1234, 3'b111);
            end
            push(BSY, 1);
            push(o(4'b0000, 2'b11, 0, 1, 1, 1), 1);
            push(o(4'b0000, 2'b01, 0, 1, 1, 1), 1);
            push(BSY, 1);
            push(IDL, 1);
            for (int k = 1; k <= 5; k++) begin
                tick();
                got = observe(); exp = exp_q.pop_front(); checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL punt%0d edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", c, k, got, exp);
                end
                if (k == 2) bus.HOST_DSACK = 2'b01;
                if (k == 3) bus.AS30 = 1'b1;
            end
            bus.HOST_DSACK = 2'b11;
        end
    endtask

    task automatic test_abort();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b01, 4'd10, 1'b0);
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b11, 1, 0, 1, 1), 2);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL abort edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 3) bus.AS30 = 1'b1;
        end
        set_win(0, 16'h00DA, 16'hFFFF, 2'b01, 4'd2, 1'b0);
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b11, 1, 0, 1, 1), 2);
        push(o(4'b0001, 2'b10, 1, 0, 1, 1), 1);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL after_abort edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 4) bus.AS30 = 1'b1;
        end
    endtask

    task automatic test_reset_mid_cycle();
        obs_t got, exp;
        clear_windows();
        set_win(0, 16'h00DA, 16'hFFFF, 2'b01, 4'd0, 1'b1);
        start_cycle(32'h00DA_0000, 3'b101);
        push(BSY, 1);
        push(o(4'b0001, 2'b00, 1, 0, 1, 1), 2);
        push(IDL, 5);
        push(BSY, 1);
        push(o(4'b0001, 2'b00, 1, 0, 1, 1), 1);
        push(BSY, 1);
        push(IDL, 1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            got = observe(); exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_mid edge %0d: got %b expected %b (sel,dsack,punt,speed,berr,busy)", k, got, exp);
            end
            if (k == 3)  rst = 1'b1;
            if (k == 4)  rst = 1'b0;
            if (k == 7)  bus.AS30 = 1'b1;
            if (k == 8)  bus.AS30 = 1'b0;
            if (k == 10) bus.AS30 = 1'b1;
        end
    endtask

    initial begin
        bus.AS30       = 1'b1;
        bus.RW30       = 1'b1;
        bus.FC         = 3'b101;
        bus.A          = '0;
        bus.HOST_DSACK = 2'b11;
        clear_windows();
        test_reset();
        test_wait_states();
        test_priority();
        test_ext_ready();
        test_timeout();
        test_punt();
        test_abort();
        test_reset_mid_cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_cycle_router.md
Name: bus_cycle_router

Overview:
- Parametrised successor to the fixed accelerator glue decode.
- Routes each 68030 bus cycle to one of NWIN programmable address windows, or punts it to the host (motherboard) bus.
- Generates per-window selects, wait-stated or ready-terminated DSACK with dynamic port sizing, the host punt/speed request, and a bus-error timeout.
- Sits between the CPU control lines and the internal responders (gayle, ATA, zorro, future peripherals).

Parameters:
- NWIN, 4, number of decode windows (1..8).
- WS_W, 4, width of per-window wait-state field.
- TIMEOUT, 64, CLKCPU cycles before BERR on an unterminated internal/external-ready cycle (2..255).

Ports:
- CLKCPU  in  1  CPU clock; all state on rising edge.
- RESET  in  1  synchronous reset, active-high.
- AS30  in  1  CPU address strobe, active-low, already synchronous to CLKCPU.
- RW30  in  1  CPU read/write (1 = read).
- FC  in  3  function code.
- A  in  32  CPU address.
- WIN_MATCH  in  NWIN*16  per-window compare value for A[31:16].
- WIN_MASK  in  NWIN*16  per-window compare mask (1 = bit compared).
- WIN_MODE  in  NWIN*2  00 disabled, 01 internal wait-state, 10 punt, 11 external-ready.
- WIN_WS  in  NWIN*WS_W  wait states for modes 01/11.
- WIN_SIZE  in  NWIN  port size: 0 = 8-bit, 1 = 32-bit.
- WIN_RDY  in  NWIN  responder ready, mode 11 only, active-high.
- HOST_DSACK  in  2  host bus DSACK[1:0], active-low.
- SEL  out  NWIN  one-hot window select, active-high.
- DSACK  out  2  DSACK[1:0] to CPU, active-low.
- PUNT  out  1  punt request, active-low.
- SPEED  out  1  slow-clock request to clock block, active-high.
- BERR  out  1  bus error, active-low.
- BUSY  out  1  high while FSM not IDLE.

Behaviour:
- Reset values: SEL = 0, DSACK = 11, PUNT = 1, SPEED = 0, BERR = 1, BUSY = 0. FSM = IDLE, counters = 0.
- RESET wins over every other event. Asserted mid-cycle, all outputs return to reset values on that edge; FSM restarts in IDLE even if AS30 is still low. A cycle still in progress after reset release is ignored until AS30 returns high.
- IDLE -> DECODE on the first edge AS30 is sampled low.
- DECODE (1 cycle):
  - Window i matches when ((A[31:16] ^ WIN_MATCH[i]) & WIN_MASK[i]) == 0 and WIN_MODE[i] != 00.
  - On multiple matches the lowest index wins.
  - CPU-space cycles (FC = 111) never match and always punt.
  - No match punts.
  - The winning index, mode, WS and size are latched. Window inputs changing later in the cycle are ignored.
  - Wait counter loads WS; timeout counter loads 0.
- DECODE -> WAIT for modes 01/11; DECODE -> PUNT otherwise.
- SEL[i] asserts on the DECODE->WAIT edge and holds until TERM exits.
- WAIT:
  - Counter decrements each cycle and saturates at 0.
  - Mode 01: at counter = 0, go to ACK. With WS = 0, DSACK is asserted on the 2nd edge after AS30 is sampled low.
  - Mode 11: go to ACK on the first edge with counter = 0 and WIN_RDY[i] = 1. RDY high before WS has elapsed is ignored.
  - Timeout counter increments in WAIT. Reaching TIMEOUT-1 -> BERRST.
- ACK:
  - DSACK = 10 (8-bit) or 00 (32-bit) per latched size.
  - Held until AS30 is sampled high, then -> TERM.
- PUNT:
  - PUNT = 0 and SPEED = 1 from the edge after DECODE.
  - DSACK = HOST_DSACK registered (one-cycle delay). No timeout.
  - AS30 high -> TERM.
- BERRST: BERR = 0, DSACK = 11, held until AS30 high -> TERM.
- TERM (1 cycle): all outputs return to reset values, BUSY stays 1, then -> IDLE. This one idle cycle is guaranteed between back-to-back cycles.
- AS30 negated in DECODE or WAIT (aborted cycle): -> TERM immediately with no DSACK/BERR pulse.
- The timeout counter is 8 bits wide and never wraps: it stops at TIMEOUT-1.

Test Plan:
- Window0 match = 16'h00DA, mask = FFFF, mode 01, WS = 3, size 8. Read at A = 00DA0000 -> SEL = 0001 from edge 2; DSACK = 10 on edge 5 after AS30 low; cleared one edge after AS30 high.
- Windows 1 and 2 both match 16'h00DA, mode 01, size 32 -> SEL = 0010 (lowest index wins); DSACK = 00.
- Mode 11, WS = 1; RDY high from edge 1; separately RDY never raised, TIMEOUT = 8 -> first case: DSACK on edge 3. Second case: BERR = 0 on edge 9, SEL held, all outputs clear after AS30 negates.
- Unmapped A = 00BFE001, and FC = 111 with A[19:16] = 1111 -> PUNT = 0, SPEED = 1 on edge 2. HOST_DSACK = 01 presented -> DSACK = 01 one edge later.
- AS30 negated during WAIT with WS = 10 -> no DSACK, no BERR; BUSY falls two edges later. Next cycle decodes normally.
- RESET pulsed during ACK with AS30 still low -> all outputs at reset values that edge. No new DECODE until AS30 has gone high and low again.
